// File: rtl/expand_bitwidth_if.sv
// Streaming bin interface for expand_bitwidth: narrowed bins in, widened bins out.
// Signal names keep the block's _i/_o direction suffixes as seen from the DUT.
interface expand_bitwidth_if #(
  parameter int IW = 8,
  parameter int OW = 10,
  parameter int EW = 3
);
  logic [2*IW-1:0] data_i;
  logic            valid_i;
  logic            sop_i;
  logic [EW-1:0]   shift_i;
  logic            ready_o;
  logic [2*OW-1:0] data_o;
  logic            valid_o;
  logic            ready_i;
  logic            sop_o;
  logic            eop_o;
  logic            sat_alarm_o;
  logic            frame_err_o;

  modport slave (
    input  data_i, valid_i, sop_i, shift_i, ready_i,
    output ready_o, data_o, valid_o, sop_o, eop_o, sat_alarm_o, frame_err_o
  );

  modport master (
    output data_i, valid_i, sop_i, shift_i, ready_i,
    input  ready_o, data_o, valid_o, sop_o, eop_o, sat_alarm_o, frame_err_o
  );
endinterface

// File: rtl/expand_bitwidth.sv
// Restores narrowed {im,re} bins to OW bits: sign-extend, apply the per-frame
// left shift latched on sop, then saturate or wrap. Single registered output stage.
module expand_bitwidth #(
  parameter int IW     = 8,
  parameter int OW     = 10,
  parameter int N      = 256,
  parameter int EW     = 3,
  parameter int SAT_EN = 1
) (
  input  logic               clk_i,
  input  logic               srst_n_i,
  expand_bitwidth_if.slave   bus
);
  localparam int XW = IW + (1 << EW) - 1;
  localparam int WW = (XW > OW) ? XW : OW;
  localparam int CW = $clog2(N);

  generate
    if (OW < IW) begin : g_bad_ow
      $fatal(1, "expand_bitwidth: OW must be >= IW");
    end
    if (N < 2) begin : g_bad_n
      $fatal(1, "expand_bitwidth: N must be >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [EW-1:0]          sh_q, sh_d;

  logic                   valid_q, valid_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic                   sat_q, sat_d;
  logic                   err_q, err_d;
  logic [1:0][OW-1:0]     data_q, data_d;

  logic [1:0][IW-1:0]     din;
  logic [EW-1:0]          sh_use;
  logic [1:0]             sat_comp;
  logic                   acc;

  assign din         = bus.data_i;
  assign bus.ready_o = !valid_q || bus.ready_i;
  assign acc         = bus.valid_i && bus.ready_o;

  // Returns {overflow, value}; overflow means the top bits above OW-1 disagree.
  function automatic logic [OW:0] expand(input logic [IW-1:0] x, input logic [EW-1:0] s);
    logic [WW-1:0] w;
    logic [WW-OW:0] hi;
    logic ovf;
    w   = {{(WW-IW){x[IW-1]}}, x};
    w   = w << s;
    hi  = w[WW-1:OW-1];
    ovf = !((&hi) || !(|hi));
    if (ovf && SAT_EN != 0)
      expand = w[WW-1] ? {1'b1, 1'b1, {(OW-1){1'b0}}} : {1'b1, 1'b0, {(OW-1){1'b1}}};
    else
      expand = {1'b0, w[OW-1:0]};
  endfunction

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // A sop beat always restarts the frame, whether we were idle or mid-frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (acc) begin
      if (bus.sop_i) begin
        state_d = ACTIVE;
        cnt_d   = CW'(1);
        sh_d    = bus.shift_i;
      end else if (state_q == ACTIVE) begin
        if (cnt_q == CW'(N-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    sh_use  = sh_q;
    if (acc) begin
      if (bus.sop_i) begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        sh_use  = bus.shift_i;
        err_d   = (state_q == ACTIVE);
      end else if (state_q == ACTIVE) begin
        valid_d = 1'b1;
        eop_d   = (cnt_q == CW'(N-1));
      end else begin
        err_d = 1'b1;
      end
    end
    for (int g = 0; g < 2; g++) begin
      {sat_comp[g], data_d[g]} = expand(din[g], sh_use);
    end
    sat_d = valid_d && (|sat_comp);
    if (!valid_d) data_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      if (bus.ready_o) begin
        valid_q <= valid_d;
        data_q  <= data_d;
        sop_q   <= sop_d;
        eop_q   <= eop_d;
        sat_q   <= sat_d;
      end
    end
  end

  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.sop_o       = sop_q;
  assign bus.eop_o       = eop_q;
  assign bus.sat_alarm_o = sat_q;
  assign bus.frame_err_o = err_q;
endmodule

// File: tb/tb_expand_bitwidth.sv
// Directed bench for expand_bitwidth: one saturating and one wrapping instance, N=4.
module tb_expand_bitwidth;
  localparam int IW = 8;
  localparam int OW = 10;
  localparam int EW = 3;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  expand_bitwidth_if #(.IW(IW), .OW(OW), .EW(EW)) b1 ();
  expand_bitwidth_if #(.IW(IW), .OW(OW), .EW(EW)) b0 ();

  expand_bitwidth #(.IW(IW), .OW(OW), .N(N), .EW(EW), .SAT_EN(1)) dut1 (
    .clk_i(clk), .srst_n_i(srst_n), .bus(b1));
  expand_bitwidth #(.IW(IW), .OW(OW), .N(N), .EW(EW), .SAT_EN(0)) dut0 (
    .clk_i(clk), .srst_n_i(srst_n), .bus(b0));

  int total = 0;
  int bad   = 0;

  task automatic drive(input logic v, input logic sop, input int sh, input int re, input int im);
    b1.valid_i = v; b1.sop_i = sop; b1.shift_i = EW'(sh); b1.data_i = {IW'(im), IW'(re)};
    b0.valid_i = v; b0.sop_i = sop; b0.shift_i = EW'(sh); b0.data_i = {IW'(im), IW'(re)};
  endtask

  task automatic set_rdy(input logic r);
    b1.ready_i = r;
    b0.ready_i = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {valid, sop, eop, sat, err, im, re}
  function automatic logic [2*OW+4:0] ex(input logic v, input logic s, input logic e,
                                         input logic sat, input logic err, input int re, input int im);
    return {v, s, e, sat, err, OW'(im), OW'(re)};
  endfunction

  function automatic logic [2*OW+4:0] ob1();
    return {b1.valid_o, b1.sop_o, b1.eop_o, b1.sat_alarm_o, b1.frame_err_o, b1.data_o};
  endfunction

  function automatic logic [2*OW+4:0] ob0();
    return {b0.valid_o, b0.sop_o, b0.eop_o, b0.sat_alarm_o, b0.frame_err_o, b0.data_o};
  endfunction

  task automatic test_reset;
    logic [2*OW+4:0] e;
    srst_n = 1'b0;
    set_rdy(1'b1);
    drive(1'b1, 1'b1, 3, 5, 5);
    tick; tick;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({ob1(), b1.ready_o} !== {e, 1'b1}) begin
      bad++; $display("FAIL reset got=%h exp=%h", {ob1(), b1.ready_o}, {e, 1'b1});
    end
    srst_n = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    tick;
  endtask

  task automatic test_basic;
    int re_v[4] = '{5, 1, -1, 7};
    int im_v[4] = '{-3, 0, 2, 7};
    logic [2*OW+4:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 1, re_v[i], im_v[i]);
      tick;
      e = ex(1, i == 0, i == 3, 0, 0, 2*re_v[i], 2*im_v[i]);
      total++;
      if (ob1() !== e) begin
        bad++; $display("FAIL basic beat%0d got=%h exp=%h", i, ob1(), e);
      end
    end
    drive(1'b0, 1'b0, 0, 0, 0);
    tick;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (ob1() !== e) begin
      bad++; $display("FAIL basic idle got=%h exp=%h", ob1(), e);
    end
  endtask

  task automatic test_sat;
    int re_v[4] = '{100, 10, -1, 0};
    int im_v[4] = '{-128, 0, -1, 15};
    int xr[4]   = '{511, 80, -8, 0};
    int xi[4]   = '{-512, 0, -8, 120};
    logic [2*OW+4:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, i == 0 ? 3 : 0, re_v[i], im_v[i]);
      tick;
      e = ex(1, i == 0, i == 3, i == 0, 0, xr[i], xi[i]);
      total++;
      if (ob1() !== e) begin
        bad++; $display("FAIL sat beat%0d got=%h exp=%h", i, ob1(), e);
      end
    end
  endtask

  task automatic test_wrap;
    int re_v[4] = '{100, 64, 3, 0};
    int im_v[4] = '{-128, -64, -3, 0};
    int wr[4]   = '{800, 512, 24, 0};
    int wi[4]   = '{-1024, -512, -24, 0};
    int sr[2]   = '{511, 511};
    int si[2]   = '{-512, -512};
    logic [2*OW+4:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 3, re_v[i], im_v[i]);
      tick;
      e = ex(1, i == 0, i == 3, 0, 0, wr[i], wi[i]);
      total++;
      if (ob0() !== e) begin
        bad++; $display("FAIL wrap beat%0d got=%h exp=%h", i, ob0(), e);
      end
      if (i < 2) begin
        e = ex(1, i == 0, 0, 1, 0, sr[i], si[i]);
        total++;
        if (ob1() !== e) begin
          bad++; $display("FAIL wrap_sat beat%0d got=%h exp=%h", i, ob1(), e);
        end
      end
    end
  endtask

  task automatic test_shift_edges;
    int re_v[8] = '{127, -1, 0, 0, 1, 4, 0, 0};
    int im_v[8] = '{-128, 1, 0, 0, -4, -5, 0, 0};
    int xr[8]   = '{127, -1, 0, 0, 128, 511, 0, 0};
    int xi[8]   = '{-128, 1, 0, 0, -512, -512, 0, 0};
    logic [2*OW+4:0] e;
    for (int i = 0; i < 8; i++) begin
      // non-sop beats carry a bogus shift that must be ignored
      drive(1'b1, (i % 4) == 0, (i < 4) ? ((i == 0) ? 0 : 7) : ((i == 4) ? 7 : 0), re_v[i], im_v[i]);
      tick;
      e = ex(1, (i % 4) == 0, (i % 4) == 3, i == 5, 0, xr[i], xi[i]);
      total++;
      if (ob1() !== e) begin
        bad++; $display("FAIL shift_edge beat%0d got=%h exp=%h", i, ob1(), e);
      end
    end
  endtask

  task automatic test_stall;
    logic [2*OW+4:0] e;
    drive(1'b1, 1'b1, 1, 1, 1);
    tick;
    e = ex(1, 1, 0, 0, 0, 2, 2);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL stall b1 got=%h exp=%h", ob1(), e); end
    drive(1'b1, 1'b0, 0, 2, 2);
    tick;
    e = ex(1, 0, 0, 0, 0, 4, 4);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL stall b2 got=%h exp=%h", ob1(), e); end
    drive(1'b1, 1'b0, 0, 3, 3);
    set_rdy(1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({ob1(), b1.ready_o} !== {e, 1'b0}) begin
        bad++; $display("FAIL stall hold%0d got=%h exp=%h", k, {ob1(), b1.ready_o}, {e, 1'b0});
      end
      if (k < 3) tick;
    end
    set_rdy(1'b1);
    tick;
    e = ex(1, 0, 0, 0, 0, 6, 6);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL stall b3 got=%h exp=%h", ob1(), e); end
    drive(1'b1, 1'b0, 0, 4, 4);
    tick;
    e = ex(1, 0, 1, 0, 0, 8, 8);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL stall b4 got=%h exp=%h", ob1(), e); end
    drive(1'b0, 1'b0, 0, 0, 0);
    tick;
  endtask

  task automatic test_premature_sop;
    int re_v[5] = '{1, 3, 1, 2, 5};
    int im_v[5] = '{1, -3, 1, 2, 5};
    int xr[5]   = '{2, 12, 4, 8, 20};
    int xi[5]   = '{2, -12, 4, 8, 20};
    logic [2*OW+4:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i < 2, (i == 0) ? 1 : ((i == 1) ? 2 : 0), re_v[i], im_v[i]);
      tick;
      e = ex(1, i < 2, i == 4, 0, i == 1, xr[i], xi[i]);
      total++;
      if (ob1() !== e) begin
        bad++; $display("FAIL premature beat%0d got=%h exp=%h", i, ob1(), e);
      end
    end
    drive(1'b0, 1'b0, 0, 0, 0);
    tick;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL premature idle got=%h exp=%h", ob1(), e); end
  endtask

  task automatic test_reset_mid;
    logic [2*OW+4:0] e;
    drive(1'b1, 1'b1, 1, 1, 1);
    tick;
    e = ex(1, 1, 0, 0, 0, 2, 2);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL rstmid b1 got=%h exp=%h", ob1(), e); end
    drive(1'b1, 1'b0, 0, 2, 2);
    srst_n = 1'b0;
    tick;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({ob1(), ob0()} !== {e, e}) begin
      bad++; $display("FAIL rstmid in_reset got=%h exp=%h", {ob1(), ob0()}, {e, e});
    end
    srst_n = 1'b1;
    drive(1'b1, 1'b0, 0, 7, 7);
    tick;
    e = ex(0, 0, 0, 0, 1, 0, 0);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL rstmid drop got=%h exp=%h", ob1(), e); end
    drive(1'b0, 1'b0, 0, 0, 0);
    tick;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (ob1() !== e) begin bad++; $display("FAIL rstmid after got=%h exp=%h", ob1(), e); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 0, 0);
    set_rdy(1'b1);
    test_reset();
    test_basic();
    test_sat();
    test_wrap();
    test_shift_edges();
    test_stall();
    test_premature_sop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/expand_bitwidth.md
Name: expand_bitwidth

Overview:
Streaming inverse of the frequency-domain bitwidth reducer. It accepts narrowed complex bins {im,re} at IW bits per component, and each frame carries a per-frame left-shift (gain exponent) supplied on its first bin. It restores each bin to OW bits by sign extension and a left shift, with optional saturation. It sits between the bin processing blocks and the inverse/resynthesis path, and has valid/ready handshakes on both sides.

Parameters:
IW, 8, input width per component (re, im).
OW, 10, output width per component; OW >= IW required (elaboration-time fatal otherwise).
N, 256, bins per frame; N >= 2.
EW, 3, width of shift_i.
SAT_EN, 1, 1 = saturate on overflow, 0 = wrap (keep low OW bits).

Ports:
clk_i  in  1  clock
srst_n_i  in  1  synchronous reset, active low
data_i  in  2*IW  {im, re}, two's complement
valid_i  in  1  input beat valid
sop_i  in  1  first bin of frame, qualified by valid_i
shift_i  in  EW  frame left-shift, sampled on the accepted sop_i beat only
ready_o  out  1  input may be accepted
data_o  out  2*OW  {im, re}, two's complement
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts
sop_o  out  1  first bin of output frame
eop_o  out  1  last (N-th) bin of output frame
sat_alarm_o  out  1  saturation occurred on this output beat (either component)
frame_err_o  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (srst_n_i=0 at a clk_i edge): valid_o=0, data_o=0, sop_o=0, eop_o=0, sat_alarm_o=0, frame_err_o=0, bin counter=0, latched shift=0, FSM=IDLE. Reset mid-frame discards the frame; no partial flush.
- Handshake: an input beat is accepted when valid_i && ready_o, and ready_o = !valid_o || ready_i. Output register has 1-cycle latency. While valid_o=1 && ready_i=0, all outputs hold and ready_o=0.
- FSM IDLE:
  - Accepted beat with sop_i=1: latch shift_i, emit the beat with sop_o=1, set counter=1, go to ACTIVE.
  - Accepted beat with sop_i=0: drop it (no output), pulse frame_err_o.
- FSM ACTIVE:
  - Accepted beat with sop_i=0: emit it, counter+1.
  - The beat with counter==N-1 is emitted with eop_o=1; counter returns to 0 and FSM goes to IDLE.
  - Accepted beat with sop_i=1 (premature sop): pulse frame_err_o, treat it as the start of a new frame (relatch shift, sop_o=1, counter=1), and stay in ACTIVE.
  - For N bins, sop on the last bin cannot occur legally; the premature-sop rule applies.
- Arithmetic, per component:
  - Sign-extend to IW+2^EW-1 bits, then shift left by the latched shift (not shift_i on non-sop beats).
  - If the result fits in OW signed bits, output it unchanged.
  - Otherwise, with SAT_EN=1: clamp to +(2^(OW-1)-1) or -2^(OW-1) and set sat_alarm_o=1 for that beat.
  - With SAT_EN=0: output the low OW bits; sat_alarm_o stays 0.
  - Shift=0 always passes the value through with no overflow.
- sop_o, eop_o and sat_alarm_o are only meaningful while valid_o=1 and are driven 0 when valid_o=0.
- frame_err_o is independent of the output stall; the error beat is accepted, so the pulse cannot occur while ready_o=0.

Test Plan:
1. IW=8, OW=10, N=4, SAT_EN=1. Frame shift=1, bins re/im = (5,-3), (1,0), (-1,2), (7,7), ready_i=1 -> outputs (10,-6), (2,0), (-2,4), (14,14), one cycle after each input; sop_o on the 1st, eop_o on the 4th; no sat.
2. shift=3, bin re=100, im=-128 -> re=511, im=-512, sat_alarm_o=1. Next bin re=10 -> 80, sat_alarm_o=0.
3. SAT_EN=0, shift=3, re=100 -> data_o re = 800 mod 1024 = -224 (0x320), sat_alarm_o=0.
4. Mid-frame, hold ready_i=0 for 3 cycles -> valid_o and data_o held constant, ready_o=0, no beats lost or duplicated. After release the frame completes with eop_o on the 4th bin.
5. sop_i asserted on bin 2 with shift=2 -> frame_err_o pulses once, that beat is emitted with sop_o=1 and shift 2 applied, and eop_o occurs 3 accepted beats later.
6. Drive srst_n_i=0 during bin 2, then release and send a beat with sop_i=0 -> all outputs 0 during reset; the post-reset beat is dropped, frame_err_o=1 for one cycle, valid_o stays 0.
